// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions two raw active-low pushbuttons and ten slide switches from the
//   DE-series board I/O. Keys are synchronized, debounced by a per-key FSM,
//   and turned into a level, press/release pulses and a long-hold flag.
//   Switches are only synchronized.
//
// Ports
//   CLK_50MHZ   in   1   sole clock, rising edge
//   RESET_N     in   1   asynchronous active-low reset (deassertion synchronized upstream)
//   KEY_IN      in   2   raw pushbuttons, active-low, asynchronous
//   SW_IN       in  10   raw slide switches, asynchronous
//   SW_OUT      out 10   synchronized switches (2-cycle latency)
//   KEY_LEVEL   out  2   debounced key state, 1 = pressed
//   KEY_PRESS   out  2   one-cycle pulse per accepted press
//   KEY_RELEASE out  2   one-cycle pulse per accepted release
//   KEY_HOLD    out  2   1 while key has been pressed at least HOLD_CYCLES
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET_N,
  input  logic [1:0] KEY_IN,
  input  logic [9:0] SW_IN,
  output logic [9:0] SW_OUT,
  output logic [1:0] KEY_LEVEL,
  output logic [1:0] KEY_PRESS,
  output logic [1:0] KEY_RELEASE,
  output logic [1:0] KEY_HOLD
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  // Switch synchronizer
  logic [9:0] sw_meta;
  logic [9:0] sw_sync;

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW_IN;
      sw_sync <= sw_meta;
    end
  end

  assign SW_OUT = sw_sync;

  // Key synchronizer. The inversion sits in front of the first flop so that
  // the reset value 0 means "released"; a key held through reset therefore
  // still has to run a full debounce afterwards.
  logic [1:0] key_meta;
  logic [1:0] key_sync;

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= ~KEY_IN;
      key_sync <= key_meta;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      state_t           state;
      state_t           state_next;
      logic [CNT_W-1:0] dcnt;
      logic [CNT_W-1:0] dcnt_next;
      logic [CNT_W-1:0] hcnt;
      logic [CNT_W-1:0] hcnt_next;
      logic             level_q;
      logic             level_next;
      logic             press_q;
      logic             release_q;
      logic             hold_q;
      logic             s;

      assign s = key_sync[gi];

      always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        hcnt_next  = hcnt;

        // Hold time keeps accumulating across a release bounce; it is only
        // cleared on a fresh accepted press.
        if ((state == PRESSED || state == RELEASE_WAIT) && hcnt != HOLD_MAX) begin
          hcnt_next = hcnt + CNT_W'(1);
        end

        case (state)
          IDLE: begin
            if (s) begin
              state_next = PRESS_WAIT;
              dcnt_next  = '0;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state_next = IDLE;
            end else if (dcnt == DEB_LAST) begin
              state_next = PRESSED;
              hcnt_next  = '0;
            end else begin
              dcnt_next = dcnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!s) begin
              state_next = RELEASE_WAIT;
              dcnt_next  = '0;
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              state_next = PRESSED;
            end else if (dcnt == DEB_LAST) begin
              state_next = IDLE;
            end else begin
              dcnt_next = dcnt + CNT_W'(1);
            end
          end
          default: state_next = IDLE;
        endcase

        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      end

      // Outputs are registered from next-state so they line up with the
      // state they describe.
      always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
          state     <= IDLE;
          dcnt      <= '0;
          hcnt      <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          hold_q    <= 1'b0;
        end else begin
          state     <= state_next;
          dcnt      <= dcnt_next;
          hcnt      <= hcnt_next;
          level_q   <= level_next;
          press_q   <= (state == PRESS_WAIT) && (state_next == PRESSED);
          release_q <= (state == RELEASE_WAIT) && (state_next == IDLE);
          hold_q    <= level_next && (hcnt_next == HOLD_MAX);
        end
      end

      assign KEY_LEVEL[gi]   = level_q;
      assign KEY_PRESS[gi]   = press_q;
      assign KEY_RELEASE[gi] = release_q;
      assign KEY_HOLD[gi]    = hold_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// A behavioural model (synchronizer delay plus "run of samples differing
// from the accepted level" debounce and "cycles since accepted press" hold
// timer) is checked against the DUT on every falling edge; directed
// sequences additionally pin exact edge counts with literal expectations.
module tb_key_conditioner;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_in = 2'b11;
  logic [9:0] sw_in = '0;
  logic [9:0] sw_out;
  logic [1:0] key_level, key_press, key_release, key_hold;

  key_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .CLK_50MHZ  (clk),
    .RESET_N    (rst_n),
    .KEY_IN     (key_in),
    .SW_IN      (sw_in),
    .SW_OUT     (sw_out),
    .KEY_LEVEL  (key_level),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release),
    .KEY_HOLD   (key_hold)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_s1, m_s2;     // synchronized active-high key samples
  logic [9:0] m_w1;
  int         run [2];        // consecutive samples disagreeing with level
  int         since [2];      // cycles since the accepted press, capped at H
  logic [1:0] e_level, e_press, e_release, e_hold;
  logic [9:0] e_sw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_w1 = '0;
      e_level = '0; e_press = '0; e_release = '0; e_hold = '0; e_sw = '0;
      for (int i = 0; i < 2; i++) begin
        run[i] = 0;
        since[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_press[i] = 1'b0;
        e_release[i] = 1'b0;
        if (m_s2[i] != e_level[i]) run[i]++;
        else run[i] = 0;
        // A new level is accepted after D+1 consecutive disagreeing samples.
        if (run[i] == D + 1) begin
          e_level[i] = ~e_level[i];
          run[i] = 0;
          if (e_level[i]) begin
            e_press[i] = 1'b1;
            since[i] = 0;
          end else begin
            e_release[i] = 1'b1;
          end
        end else if (e_level[i] && since[i] < H) begin
          since[i]++;
        end
        e_hold[i] = e_level[i] && (since[i] == H);
      end
      m_s2 = m_s1;
      m_s1 = ~key_in;
      e_sw = m_w1;
      m_w1 = sw_in;
    end
  end

  always @(negedge clk) begin
    chk("model_level",   {30'd0, key_level},   {30'd0, e_level});
    chk("model_press",   {30'd0, key_press},   {30'd0, e_press});
    chk("model_release", {30'd0, key_release}, {30'd0, e_release});
    chk("model_hold",    {30'd0, key_hold},    {30'd0, e_hold});
    chk("model_sw",      {22'd0, sw_out},      {22'd0, e_sw});
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {sw_out, key_level, key_press, key_release, key_hold}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released, outputs idle");

    // Switch path: two-edge latency
    @(negedge clk);
    sw_in = 10'h2A5;
    edge1();
    chk("sw_edge1", {22'd0, sw_out}, 32'd0);
    edge1();
    chk("sw_edge2", {22'd0, sw_out}, 32'h2A5);
    $display("switch 2A5 -> SW_OUT %h", sw_out);

    // Clean press of KEY0: pulse after edge 7, hold after edge 17
    @(negedge clk);
    key_in = 2'b10;
    for (int e = 1; e <= 18; e++) begin
      edge1();
      chk($sformatf("press0_e%0d", e), {31'd0, key_press[0]}, {31'd0, (e == 7)});
      chk($sformatf("level0_e%0d", e), {31'd0, key_level[0]}, {31'd0, (e >= 7)});
      chk($sformatf("hold0_e%0d", e),  {31'd0, key_hold[0]},  {31'd0, (e >= 17)});
    end
    $display("KEY0 press accepted, hold flag %b", key_hold[0]);

    // Release bounce of 2 cycles while pressed: no release
    @(negedge clk);
    key_in = 2'b11;
    repeat (2) @(negedge clk);
    key_in = 2'b10;
    for (int e = 1; e <= 10; e++) begin
      edge1();
      chk($sformatf("bounce_rel_e%0d", e), {30'd0, key_release, key_level[0]}, 32'd1);
    end
    $display("KEY0 release bounce ignored");

    // Clean release
    @(negedge clk);
    key_in = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      edge1();
      chk($sformatf("release0_e%0d", e), {31'd0, key_release[0]}, {31'd0, (e == 7)});
      chk($sformatf("rlevel0_e%0d", e),  {31'd0, key_level[0]},   {31'd0, (e < 7)});
    end
    $display("KEY0 release accepted");

    // Press bounce of 3 cycles: nothing accepted
    @(negedge clk);
    key_in = 2'b10;
    repeat (3) @(negedge clk);
    key_in = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      edge1();
      chk($sformatf("bounce_press_e%0d", e), {30'd0, key_press, key_level[0]}, 32'd0);
    end
    $display("KEY0 press bounce ignored");

    // Both keys together
    @(negedge clk);
    key_in = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      edge1();
      chk($sformatf("both_press_e%0d", e), {30'd0, key_press}, (e == 7) ? 32'd3 : 32'd0);
    end
    @(negedge clk);
    key_in = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      edge1();
      chk($sformatf("both_rel_e%0d", e), {30'd0, key_release}, (e == 7) ? 32'd3 : 32'd0);
    end
    $display("both keys pressed and released together");

    // Reset mid-press, key still held afterwards
    @(negedge clk);
    key_in = 2'b10;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_level", {31'd0, key_level[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {sw_out, key_level, key_press, key_release, key_hold}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      edge1();
      chk($sformatf("rst_press_e%0d", e), {31'd0, key_press[0]}, {31'd0, (e == 7)});
      chk($sformatf("rst_norel_e%0d", e), {30'd0, key_release}, 32'd0);
    end
    $display("reset during press: fresh press after debounce");
    @(negedge clk);
    key_in = 2'b11;
    repeat (10) @(negedge clk);

    // Randomized phase, alternating fast and slow toggling
    for (int c = 0; c < 4000; c++) begin
      int thr;
      @(negedge clk);
      thr = ((c / 200) % 2) ? 2 : 15;
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(thr) == 0) key_in[i] = ~key_in[i];
      end
      if ($urandom_range(15) == 0) sw_in = 10'($urandom);
      if ($urandom_range(999) == 0) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
      end
    end
    $display("random phase complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of stable synchronized cycles required to accept a key edge (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter HOLD_CYCLES, default 25000000, SHALL set the number of cycles pressed before the hold flag asserts (0.5 s); legal range DEBOUNCE_CYCLES+1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 25, SHALL set the width of every per-key counter.
REQ-004 CLK_50MHZ  input  1  sole clock, all flops rising-edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 KEY_IN  input  2  raw pushbuttons (bit0=KEY0, bit1=KEY1), active-low, asynchronous to the clock.
REQ-007 SW_IN  input  10  raw slide switches, asynchronous.
REQ-008 SW_OUT  output  10  synchronized switches.
REQ-009 KEY_LEVEL  output  2  debounced key state, 1 = pressed.
REQ-010 KEY_PRESS  output  2  one-cycle pulse per accepted press.
REQ-011 KEY_RELEASE  output  2  one-cycle pulse per accepted release.
REQ-012 KEY_HOLD  output  2  level, 1 = key held at least HOLD_CYCLES.

Function
REQ-013 Each KEY_IN bit SHALL pass through a 2-flop synchronizer and be inverted; s[i] denotes the synchronized active-high value.
REQ-014 SW_IN SHALL pass through a 2-flop synchronizer to SW_OUT, giving 2-cycle latency with no debounce.
REQ-015 Each key SHALL have an independent FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a debounce counter dcnt and a hold counter hcnt.
REQ-016 IDLE: s=1 -> PRESS_WAIT with dcnt=0; otherwise stay.
REQ-017 PRESS_WAIT: s=0 -> IDLE with no pulse; s=1 and dcnt=DEBOUNCE_CYCLES-1 -> PRESSED with hcnt=0; otherwise dcnt+1.
REQ-018 PRESSED: s=0 -> RELEASE_WAIT with dcnt=0; otherwise stay.
REQ-019 RELEASE_WAIT: s=1 -> PRESSED with no pulse and hcnt retained; s=0 and dcnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise dcnt+1.
REQ-020 hcnt SHALL increment in PRESSED and RELEASE_WAIT, saturate at HOLD_CYCLES, and never wrap.
REQ-021 All outputs SHALL be registered.
REQ-022 KEY_LEVEL[i] SHALL be 1 exactly while the FSM is in PRESSED or RELEASE_WAIT.
REQ-023 KEY_PRESS[i] SHALL be high for exactly the one cycle after the PRESS_WAIT->PRESSED transition.
REQ-024 KEY_RELEASE[i] SHALL be high for exactly the one cycle after the RELEASE_WAIT->IDLE transition.
REQ-025 KEY_HOLD[i] SHALL be 1 while hcnt=HOLD_CYCLES and KEY_LEVEL[i]=1, and 0 otherwise.
REQ-026 Latency: a clean raw press SHALL produce KEY_PRESS in the cycle after rising edge DEBOUNCE_CYCLES+3, counting the first edge after the raw change as edge 1; a clean raw release has identical release latency.
REQ-027 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and leave KEY_LEVEL unchanged.
REQ-028 KEY_PRESS and KEY_RELEASE SHALL alternate strictly per key, never two of the same kind in a row.
REQ-029 Both keys MAY pulse in the same cycle, each handled independently.
REQ-030 Keys pressed together SHALL have no priority or interaction between them.

Reset
REQ-031 RESET_N=0 SHALL immediately force all FSMs to IDLE, all counters and synchronizer flops to 0, and every output to 0, without waiting for a clock edge.
REQ-032 A reset asserted mid-press SHALL cause no KEY_RELEASE pulse.
REQ-033 After deassertion with a key already held, a full debounce SHALL run before KEY_PRESS asserts.
REQ-034 RESET_N SHALL be deassertion-synchronized externally; the block does not synchronize it.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-035 KEY_IN[0] 1->0 held -> KEY_PRESS[0] single pulse after edge 7, KEY_LEVEL[0]=1 from the same cycle; KEY_HOLD[0]=1 ten cycles after entering PRESSED.
REQ-036 KEY_IN[0] low for 3 cycles then high -> no KEY_PRESS, KEY_LEVEL stays 0.
REQ-037 While pressed, KEY_IN[0] high for 2 cycles then low again -> no KEY_RELEASE, KEY_LEVEL stays 1, KEY_HOLD timing unaffected.
REQ-038 Both keys pressed on the same edge -> KEY_PRESS=2'b11 in one cycle; release both -> KEY_RELEASE=2'b11 in one cycle.
REQ-039 RESET_N pulsed low while KEY_LEVEL=1 -> all outputs 0 asynchronously, no KEY_RELEASE, and a fresh KEY_PRESS 7 edges after deassertion if the key is still held.
REQ-040 SW_IN=10'h2A5 -> SW_OUT=10'h2A5 two edges later; reset drives SW_OUT to 0.
